// File: rtl/micro_core_pkg.sv
// Shared definitions for micro_core: opcodes, FSM state encoding and
// instruction field layout helpers.
package micro_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SAR  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        F_IMM,
        F_RS,
        F_RD,
        F_OPCODE
    } field_e;

    // Word layout is {opcode[3:0], rd[aw-1:0], rs[aw-1:0], imm[dw-1:0]}, MSB first.
    function automatic int field_lsb(input field_e fld, input int aw, input int dw);
        case (fld)
            F_IMM:   return 0;
            F_RS:    return dw;
            F_RD:    return dw + aw;
            default: return dw + 2 * aw;
        endcase
    endfunction

    function automatic int instr_width(input int aw, input int dw);
        return 4 + 2 * aw + dw;
    endfunction

endpackage

// File: rtl/micro_core_alu.sv
// Combinational ALU for micro_core. Unflagged opcodes pass b through so the
// same result path serves LDI and MOV.
module micro_core_alu
    import micro_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              sign,
    output logic              overflow,
    output logic              zero
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;

    always_comb begin
        wide     = '0;
        result   = b;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                result   = wide[MSB:0];
                carry    = wide[DATA_W];
                overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // The extra bit of the difference is the borrow (a < b unsigned).
                wide     = {1'b0, a} - {1'b0, b};
                result   = wide[MSB:0];
                carry    = wide[DATA_W];
                overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SAR: begin
                result = {a[MSB], a[MSB:1]};
                carry  = a[0];
            end
            default: ;
        endcase
    end

    assign sign = result[MSB];
    assign zero = (result == '0);

endmodule

// File: rtl/micro_core.sv
// Multi-cycle register-file core: one instruction per valid/ready accept,
// executed through DECODE/EXEC/WB before the next accept.
//
//   state  | meaning
//   IDLE   | ready for an instruction; accept latches IR
//   DECODE | read rd/rs operands from the register file
//   EXEC   | ALU result into holding register, flags updated
//   WB     | write rd or drive data_out; HALT opcode parks the core
//   HALT   | ignores instructions until reset
module micro_core
    import micro_core_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 4,
    parameter int  OUT_W    = 8,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int INSTR_W  = instr_width(AW, DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               instr_ready,
    output logic [OUT_W-1:0]   data_out,
    output logic               out_valid,
    output logic               flag_carry,
    output logic               flag_sign,
    output logic               flag_overflow,
    output logic               flag_zero,
    output logic               halted
);

    localparam int IMM_LSB = field_lsb(F_IMM, AW, DATA_W);
    localparam int RS_LSB  = field_lsb(F_RS, AW, DATA_W);
    localparam int RD_LSB  = field_lsb(F_RD, AW, DATA_W);
    localparam int OP_LSB  = field_lsb(F_OPCODE, AW, DATA_W);

    state_t              state;
    state_t              state_next;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   res_q;

    logic [3:0]          opcode;
    logic [AW-1:0]       rd_idx;
    logic [AW-1:0]       rs_idx;
    logic [DATA_W-1:0]   imm;
    logic                accept;
    logic                writes_rd;
    logic                sets_flags;

    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_sign;
    logic                alu_overflow;
    logic                alu_zero;

    assign opcode     = ir[OP_LSB +: 4];
    assign rd_idx     = ir[RD_LSB +: AW];
    assign rs_idx     = ir[RS_LSB +: AW];
    assign imm        = ir[IMM_LSB +: DATA_W];
    assign accept     = instr_valid && instr_ready;
    assign writes_rd  = (opcode >= OP_LDI) && (opcode <= OP_SAR);
    assign sets_flags = (opcode >= OP_ADD) && (opcode <= OP_SAR);
    assign alu_b      = (opcode == OP_LDI) ? imm : rs_val;

    micro_core_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .opcode   (opcode),
        .a        (rd_val),
        .b        (alu_b),
        .result   (alu_result),
        .carry    (alu_carry),
        .sign     (alu_sign),
        .overflow (alu_overflow),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: state_next = EXEC;
            EXEC:   state_next = WB;
            WB:     state_next = (opcode == OP_HALT) ? HALT : IDLE;
            HALT:   halted = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir            <= '0;
            rd_val        <= '0;
            rs_val        <= '0;
            res_q         <= '0;
            data_out      <= '0;
            out_valid     <= 1'b0;
            flag_carry    <= 1'b0;
            flag_sign     <= 1'b0;
            flag_overflow <= 1'b0;
            flag_zero     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ir <= instr_in;
                    end
                end
                DECODE: begin
                    rd_val <= regs[rd_idx];
                    rs_val <= regs[rs_idx];
                end
                EXEC: begin
                    res_q <= alu_result;
                    if (sets_flags) begin
                        flag_carry    <= alu_carry;
                        flag_sign     <= alu_sign;
                        flag_overflow <= alu_overflow;
                        flag_zero     <= alu_zero;
                    end
                end
                WB: begin
                    if (writes_rd) begin
                        regs[rd_idx] <= res_q;
                    end
                    if (opcode == OP_OUT) begin
                        data_out  <= rs_val[OUT_W-1:0];
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/micro_core.md
# micro_core

Parametrised multi-cycle successor to the fixed 16-bit accumulator CPU. It accepts one instruction word per valid/ready handshake and executes it through a four-state fetch/decode/execute/writeback FSM. Operands come from a NUM_REGS-entry register file, and results are written back to it. It exposes carry/sign/overflow/zero flags and a strobed output port. It replaces the single-cycle core at the top of the CPU subsystem.

## Interface
- DATA_W, 16: register, ALU and immediate width (≥ 8).
- NUM_REGS, 4: register file depth (power of two, ≥ 2); AW = log2(NUM_REGS).
- OUT_W, 8: data_out width (≤ DATA_W).
- INSTR_W (derived) = 4 + 2·AW + DATA_W. The instruction word is {opcode[3:0], rd[AW-1:0], rs[AW-1:0], imm[DATA_W-1:0]}, MSB first.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instr_in holds a valid instruction.
- instr_in  in  INSTR_W  instruction word.
- instr_ready  out  1  core can accept an instruction (high only in IDLE).
- data_out  out  OUT_W  last value output by OUT.
- out_valid  out  1  one-cycle strobe when data_out is updated.
- flag_carry, flag_sign, flag_overflow, flag_zero  out  1 each  ALU flags.
- halted  out  1  core has executed HALT.

## Operation
Opcodes:
- 0 NOP.
- 1 LDI: rd ← imm.
- 2 MOV: rd ← rs.
- 3 ADD: rd ← rd + rs.
- 4 SUB: rd ← rd − rs.
- 5 AND, 6 OR, 7 XOR: bitwise, rd ← rd op rs.
- 8 SHL: rd ← rd << 1.
- 9 SAR: rd ← rd >>> 1 (arithmetic).
- A OUT: data_out ← rs[OUT_W-1:0], pulse out_valid.
- F HALT.
- B–E: illegal, executed as NOP.

ALU and flags:
- All arithmetic is modulo 2^DATA_W; operands are two's complement.
- Flags update only for opcodes 3–9. All other opcodes leave the flags unchanged.
- ADD: carry = carry-out of the MSB.
- SUB: carry = borrow, i.e. 1 when rd < rs unsigned.
- SHL: carry = bit shifted out of the MSB.
- SAR: carry = bit shifted out of the LSB.
- AND/OR/XOR: carry = 0 and overflow = 0.
- Overflow (ADD/SUB only) = signed overflow.
- sign = result MSB; zero = (result == 0).

FSM states:
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr_in into IR and go to DECODE.
- DECODE: latch rd_val and rs_val from the register file; go to EXEC.
- EXEC: compute the result and the new flags into holding registers; latch the flags; go to WB.
- WB: write rd (opcodes 1–9), or update data_out (OUT). Next state is HALT if the opcode is F, else IDLE.
- HALT: instr_ready = 0 and halted = 1 until rst. Instructions are ignored.

Hazards: none. The writeback completes before the next DECODE, so a dependent instruction always reads the updated value. rd == rs is legal.

## Timing
Reset values:
- Register file, IR, data_out and all flags: 0.
- out_valid = 0, halted = 0.
- State = IDLE, so instr_ready = 1 in the first cycle after rst deasserts.

Instruction latency, for an accept at rising edge N:
- Edge N: IR loaded; state → DECODE.
- Edge N+1: operands latched; state → EXEC.
- Edge N+2: flags valid.
- Edge N+3: rd and data_out valid. out_valid is high for exactly the cycle after edge N+3.
- Next accept is edge N+4 at the earliest. Peak throughput is 1 instruction per 4 cycles.

Handshake rules:
- instr_in is sampled only on an accept edge; it is ignored while instr_ready = 0.
- Holding instr_valid high without a change does not repeat execution. Each accept edge consumes the word on instr_in at that edge.

Reset mid-instruction: asserting rst in any state aborts immediately. No writeback occurs and all outputs go to their reset values.

## Structure
- Package micro_core_pkg holds the opcode localparams, the state enum (IDLE/DECODE/EXEC/WB/HALT), and the instruction field-slicing function parametrised by AW and DATA_W.
- Sub-module micro_core_alu is combinational and parametrised by DATA_W. It takes opcode, a and b, and returns the result plus carry/sign/overflow/zero.
- The register file and FSM are inline in micro_core.

## Test plan
All scenarios use the default parameters.
- Reset: pulse rst mid-cycle (asynchronous) → all outputs 0; instr_ready = 1 on the next cycle.
- Signed overflow: LDI r1,0x7FFF; LDI r2,0x0002; ADD r1,r2; OUT r1 → data_out = 0x01 with a one-cycle out_valid; overflow = 1, sign = 1, carry = 0, zero = 0.
- Borrow: LDI r0,3; LDI r3,5; SUB r0,r3 → r0 = 0xFFFE (verified via OUT → 0xFE); carry = 1, sign = 1, overflow = 0.
- Shift and zero: LDI r1,0x8000; SHL r1 → r1 = 0, carry = 1, zero = 1. Then LDI r2,0x8001; SAR r2 → 0xC000, carry = 1, sign = 1.
- Handshake: instr_valid held high with a new LDI each accept → accepts exactly every 4 cycles; words presented while ready = 0 are ignored. instr_valid low → core stays in IDLE with all state unchanged.
- HALT and abort: HALT followed by LDI r0,5 → halted = 1, instr_ready = 0, r0 unchanged; rst recovers the core. Asserting rst during EXEC of ADD → no writeback, flags = 0, state IDLE.
